// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x3 keypad scanner.
//   - Debounce FSM state encoding and frame classification codes.
//   - Special key indices (star, hash, none).
//   - Row/column to key-index map.
// Optional feature macro: KEYPAD_STAR_HASH_EN (used by the scanner and debounce files).
package keypad_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConfirm,
    StHeld,
    StRelease
  } deb_state_e;

  typedef enum logic [1:0] {
    FrNone,
    FrSingle,
    FrMulti
  } frame_class_e;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'hF;

  localparam int unsigned NumKeys = 12;

  // Rows 0..2 hold digits 1..9 in reading order; row 3 is star, 0, hash.
  function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] idx;
    if (row == 2'd3) begin
      case (col)
        2'd0:    idx = KEY_STAR;
        2'd1:    idx = 4'd0;
        default: idx = KEY_HASH;
      endcase
    end else begin
      idx = 4'(row) * 4'd3 + 4'(col) + 4'd1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-level debounce FSM with registered key outputs.
// Ports:
//   clk_i          clock, rising edge
//   clear_i        synchronous active-high reset
//   frame_done_i   one-clock strobe at the end of each scan frame
//   frame_class_i  NONE / SINGLE / MULTI for the completed frame
//   frame_key_i    key index when the frame is SINGLE
//   keyboard_o     one-hot digit bus (digits 0..9 only)
//   key_valid_o    one-clock pulse per accepted press
//   key_code_o     index of the held key, KEY_NONE when idle
//   key_star_o/key_hash_o  only with KEYPAD_STAR_HASH_EN defined
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic         clk_i,
  input  logic         clear_i,
  input  logic         frame_done_i,
  input  frame_class_e frame_class_i,
  input  logic [3:0]   frame_key_i,
  output logic [9:0]   keyboard_o,
  output logic         key_valid_o,
  output logic [3:0]   key_code_o
`ifdef KEYPAD_STAR_HASH_EN
  ,
  output logic         key_star_o,
  output logic         key_hash_o
`endif
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CntW-1:0] CntDone = CntW'(DEBOUNCE_FRAMES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  deb_state_e      state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;
  logic            is_cand;

  logic [9:0] keyboard_q, keyboard_d;
  logic       key_valid_q, key_valid_d;
  logic [3:0] key_code_q, key_code_d;
`ifdef KEYPAD_STAR_HASH_EN
  logic key_star_q, key_star_d;
  logic key_hash_q, key_hash_d;
`endif

  assign is_cand = (frame_class_i == FrSingle) && (frame_key_i == cand_q);

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q     <= StIdle;
      cand_q      <= KEY_NONE;
      cnt_q       <= '0;
      keyboard_q  <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= KEY_NONE;
`ifdef KEYPAD_STAR_HASH_EN
      key_star_q  <= 1'b0;
      key_hash_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      keyboard_q  <= keyboard_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
`ifdef KEYPAD_STAR_HASH_EN
      key_star_q  <= key_star_d;
      key_hash_q  <= key_hash_d;
`endif
    end
  end

  // Next state: only evaluated on the frame-end strobe.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (frame_done_i) begin
      unique case (state_q)
        StIdle: begin
          if (frame_class_i == FrSingle) begin
            cand_d = frame_key_i;
            cnt_d  = CntOne;
            if (DEBOUNCE_FRAMES == 1) begin
              state_d = StHeld;
              accept  = 1'b1;
            end else begin
              state_d = StConfirm;
            end
          end
        end
        StConfirm: begin
          if (is_cand) begin
            cnt_d = cnt_q + CntOne;
            if (cnt_d == CntDone) begin
              state_d = StHeld;
              accept  = 1'b1;
            end
          end else begin
            state_d = StIdle;
            cand_d  = KEY_NONE;
            cnt_d   = '0;
          end
        end
        StHeld: begin
          if (!is_cand) begin
            // A single NONE frame is already a full release when one frame suffices.
            if ((DEBOUNCE_FRAMES == 1) && (frame_class_i == FrNone)) begin
              state_d = StIdle;
              cand_d  = KEY_NONE;
              cnt_d   = '0;
            end else begin
              state_d = StRelease;
              cnt_d   = CntOne;
            end
          end
        end
        StRelease: begin
          if (frame_class_i == FrNone) begin
            cnt_d = cnt_q + CntOne;
            if (cnt_d >= CntDone) begin
              state_d = StIdle;
              cand_d  = KEY_NONE;
              cnt_d   = '0;
            end
          end else if (is_cand) begin
            state_d = StHeld;
          end else begin
            cnt_d = CntOne;
          end
        end
        default: begin
          state_d = StIdle;
          cand_d  = KEY_NONE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output next values, registered alongside the state.
  always_comb begin
    key_valid_d = accept;
    key_code_d  = key_code_q;
    keyboard_d  = keyboard_q;
    if (state_d == StIdle || state_d == StConfirm) begin
      key_code_d = KEY_NONE;
      keyboard_d = '0;
    end else if (accept) begin
      key_code_d = cand_d;
      keyboard_d = (cand_d <= 4'd9) ? (10'd1 << cand_d) : '0;
    end
`ifdef KEYPAD_STAR_HASH_EN
    key_star_d = (state_d == StHeld || state_d == StRelease) && (cand_d == KEY_STAR);
    key_hash_d = (state_d == StHeld || state_d == StRelease) && (cand_d == KEY_HASH);
`endif
  end

  assign keyboard_o  = keyboard_q;
  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;
`ifdef KEYPAD_STAR_HASH_EN
  assign key_star_o  = key_star_q;
  assign key_hash_o  = key_hash_q;
`endif

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 matrix keypad scanner with frame-level debounce.
// Ports:
//   clk        clock, rising edge
//   clear      synchronous active-high reset
//   col_n      column sense, active-low, asynchronous
//   row_n      row drive, active-low, one row low at a time
//   keyboard   one-hot digit bus, bit d = digit d held
//   key_valid  one-clock pulse per accepted press
//   key_code   held key index, 4'hF when none
//   key_star, key_hash  present only when KEYPAD_STAR_HASH_EN is defined
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] keyboard,
  output logic       key_valid,
  output logic [3:0] key_code
`ifdef KEYPAD_STAR_HASH_EN
  ,
  output logic       key_star,
  output logic       key_hash
`endif
);

  localparam int unsigned DwellW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);

  logic [2:0]         col_meta_q, col_sync_q;
  logic [1:0]         row_q;
  logic [DwellW-1:0]  dwell_q;
  logic [NumKeys-1:0] frame_q;
  logic [NumKeys-1:0] row_hits, frame_keys;
  logic               row_last, frame_done;
  logic [3:0]         hit_cnt, hit_key;
  frame_class_e       frame_class;

  assign row_last   = (dwell_q == DwellLast);
  assign frame_done = row_last && (row_q == 2'd3);
  assign row_n      = ~(4'b0001 << row_q);

  // Keys seen on the current row, merged with earlier rows of this frame.
  always_comb begin
    row_hits = '0;
    for (int c = 0; c < 3; c++) begin
      if (!col_sync_q[c]) row_hits[key_index(row_q, 2'(c))] = 1'b1;
    end
    frame_keys = frame_q | row_hits;
  end

  always_comb begin
    hit_cnt = '0;
    hit_key = KEY_NONE;
    for (int k = 0; k < NumKeys; k++) begin
      if (frame_keys[k]) begin
        hit_cnt = hit_cnt + 4'd1;
        hit_key = 4'(k);
      end
    end
    if (hit_cnt == 4'd0)      frame_class = FrNone;
    else if (hit_cnt == 4'd1) frame_class = FrSingle;
    else                      frame_class = FrMulti;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      col_meta_q <= 3'b111;
      col_sync_q <= 3'b111;
      row_q      <= '0;
      dwell_q    <= '0;
      frame_q    <= '0;
    end else begin
      col_meta_q <= col_n;
      col_sync_q <= col_meta_q;
      if (row_last) begin
        dwell_q <= '0;
        row_q   <= row_q + 2'd1;
        // Columns are sampled only here, on the last clock of the dwell.
        frame_q <= frame_done ? '0 : frame_keys;
      end else begin
        dwell_q <= dwell_q + DwellW'(1);
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk_i        (clk),
    .clear_i      (clear),
    .frame_done_i (frame_done),
    .frame_class_i(frame_class),
    .frame_key_i  (hit_key),
    .keyboard_o   (keyboard),
    .key_valid_o  (key_valid),
    .key_code_o   (key_code)
`ifdef KEYPAD_STAR_HASH_EN
    ,
    .key_star_o   (key_star),
    .key_hash_o   (key_hash)
`endif
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (16-clock frames).
// A keypad model drives col_n from row_n and the set of pressed keys; key sets change
// only right after a frame end, so every frame sees one consistent set.
module tb_keypad_scanner;

  localparam int Div   = 4;
  localparam int Df    = 3;
  localparam int Frame = 4 * Div;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [9:0] keyboard;
  logic       key_valid;
  logic [3:0] key_code;
`ifdef KEYPAD_STAR_HASH_EN
  logic       key_star;
  logic       key_hash;
`endif

  keypad_scanner #(
    .SCAN_DIV       (Div),
    .DEBOUNCE_FRAMES(Df)
  ) dut (
    .clk      (clk),
    .clear    (clear),
    .col_n    (col_n),
    .row_n    (row_n),
    .keyboard (keyboard),
    .key_valid(key_valid),
    .key_code (key_code)
`ifdef KEYPAD_STAR_HASH_EN
    ,
    .key_star (key_star),
    .key_hash (key_hash)
`endif
  );

  always #5 clk = ~clk;

  int key_at[4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};

  logic [11:0] pressed = '0;

  // Physical keypad: a pressed key shorts its column to any row driven low.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!row_n[r] && pressed[key_at[r][c]]) col_n[c] = 1'b0;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: acc = accepted key (-1 none), run_* = candidate streak,
  // rel = release progress while a key is accepted (0 = firmly held).
  int   acc, run_key, run_len, rel;
  logic exp_valid;
  int   phase;

  task automatic model_reset();
    acc       = -1;
    run_key   = -1;
    run_len   = 0;
    rel       = 0;
    exp_valid = 1'b0;
    phase     = 0;
  endtask

  task automatic model_frame(input logic [11:0] keys);
    int n;
    int k;
    bit single;
    n = $countones(keys);
    k = -1;
    for (int i = 0; i < 12; i++) if (keys[i]) k = i;
    single = (n == 1);
    if (acc < 0) begin
      if (run_len > 0) begin
        if (single && k == run_key) run_len++;
        else run_len = 0;
      end else if (single) begin
        run_key = k;
        run_len = 1;
      end
      if (run_len >= Df) begin
        acc       = run_key;
        run_len   = 0;
        rel       = 0;
        exp_valid = 1'b1;
      end
    end else begin
      if (single && k == acc) rel = 0;
      else if (rel == 0 || n != 0) rel = 1;
      else rel++;
      if (rel >= Df) acc = -1;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_code;
    logic [9:0] exp_kb;
    logic [3:0] exp_row;
    exp_code = (acc < 0) ? 4'hF : 4'(acc);
    exp_kb   = (acc >= 0 && acc <= 9) ? (10'd1 << acc) : 10'd0;
    exp_row  = ~(4'b0001 << ((phase / Div) % 4));
    check_eq("row_n", row_n, exp_row);
    check_eq("key_valid", key_valid, exp_valid);
    check_eq("key_code", key_code, exp_code);
    check_eq("keyboard", keyboard, exp_kb);
`ifdef KEYPAD_STAR_HASH_EN
    check_eq("key_star", key_star, (acc == 10));
    check_eq("key_hash", key_hash, (acc == 11));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    phase++;
    exp_valid = 1'b0;
    if (phase == Frame) begin
      phase = 0;
      model_frame(pressed);
    end
    check_outputs();
  endtask

  task automatic run_frames(input logic [11:0] keys, input int n);
    pressed = keys;
    for (int f = 0; f < n; f++) begin
      for (int i = 0; i < Frame; i++) tick();
    end
  endtask

  task automatic do_reset();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
    check_eq("reset_row_n", row_n, 4'b1110);
    check_eq("reset_valid", key_valid, 1'b0);
    check_eq("reset_code", key_code, 4'hF);
    check_eq("reset_keyboard", keyboard, 10'd0);
  endtask

  function automatic logic [11:0] k1(input int a);
    logic [11:0] m;
    m = '0;
    m[a] = 1'b1;
    return m;
  endfunction

  logic [11:0] rnd_keys = '0;

  initial begin
    model_reset();
    do_reset();

    // Idle scanning with no key.
    run_frames('0, 13);

    // Key 5 held for 10 frames, then released.
    run_frames(k1(5), 10);
    run_frames('0, 5);

    // Key 7 with a one-frame bounce during confirmation.
    run_frames(k1(7), 1);
    run_frames('0, 1);
    run_frames(k1(7), 4);
    run_frames('0, 4);

    // Key 2 held, 8 joins (multi), 8 lifted again.
    run_frames(k1(2), 4);
    run_frames(k1(2) | k1(8), 1);
    run_frames(k1(2), 3);
    run_frames('0, 4);

    // Clear mid-frame while 9 is held; 9 stays down afterwards.
    run_frames(k1(9), 4);
    for (int i = 0; i < 7; i++) tick();
    do_reset();
    run_frames(k1(9), 4);
    run_frames('0, 4);

    // Hash key.
    run_frames(k1(11), 4);
    run_frames('0, 4);

    // Star key.
    run_frames(k1(10), 4);
    run_frames('0, 4);

    // Random key activity.
    for (int f = 0; f < 200; f++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        rnd_keys = rnd_keys;
      end else if (r < 7) begin
        rnd_keys = '0;
      end else if (r < 9) begin
        rnd_keys = k1(int'($urandom_range(0, 11)));
      end else begin
        rnd_keys = k1(int'($urandom_range(0, 11))) | k1(int'($urandom_range(0, 11)));
      end
      run_frames(rnd_keys, 1);
    end
    run_frames('0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning clocks each row is driven (min 4).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 4, meaning consecutive identical frames needed to accept a press or a release (min 1).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port clear  input  1  synchronous, active-high reset.
REQ-005 SHALL have port col_n  input  3  keypad column sense, active-low (pulled up), asynchronous to clk.
REQ-006 SHALL have port row_n  output  4  keypad row drive, active-low, exactly one row low at any time.
REQ-007 SHALL have port keyboard  output  10  one-hot digit bus for the timer-entry block, bit d = digit d held.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse on each accepted new press.
REQ-009 SHALL have port key_code  output  4  index of the held key, 4'hF when none.

Function
REQ-010 SHALL pass col_n through a 2-flop synchronizer before use.
REQ-011 SHALL drive row r (r=0..3) for SCAN_DIV clocks, then advance to r+1, wrapping 3->0. A frame is 4*SCAN_DIV clocks.
REQ-012 SHALL sample the synchronized columns on the last clock of each row dwell only.
REQ-013 SHALL map keys as: row0 = 1,2,3; row1 = 4,5,6; row2 = 7,8,9; row3 = star(10), 0, hash(11), listed in column order 0..2.
REQ-014 SHALL classify each completed frame as NONE (no key), SINGLE k (exactly one key), or MULTI (two or more keys). MULTI SHALL be treated as a value equal to no candidate and as not NONE.
REQ-015 SHALL implement a debounce FSM with states IDLE, CONFIRM, HELD and RELEASE, evaluated once per frame end. It SHALL carry cand (key index) and cnt.
REQ-016 In IDLE: on SINGLE k, SHALL set cand=k, cnt=1, and go to CONFIRM. With DEBOUNCE_FRAMES=1 it SHALL go directly to HELD.
REQ-017 In CONFIRM: on SINGLE cand, SHALL increment cnt; when cnt reaches DEBOUNCE_FRAMES it SHALL go to HELD. Any other frame SHALL return to IDLE.
REQ-018 On entering HELD: SHALL pulse key_valid for exactly 1 clock (the clock after the frame end). key_code SHALL become cand. keyboard SHALL become the one-hot of cand if cand<=9, otherwise all-zero.
REQ-019 In HELD: on SINGLE cand, SHALL stay in HELD. Any other frame SHALL go to RELEASE with cnt=1.
REQ-020 In RELEASE: on NONE, SHALL increment cnt; at DEBOUNCE_FRAMES it SHALL go to IDLE and clear keyboard and key_code in the same clock.
REQ-021 In RELEASE: on SINGLE cand, SHALL return to HELD with no new key_valid pulse. On MULTI or a different key, SHALL stay in RELEASE with cnt=1.
REQ-022 keyboard, key_code and key_valid SHALL be registered. keyboard SHALL never have more than one bit set.
REQ-023 Scan counters SHALL be sized $clog2 of their terminal value and SHALL never overflow.

Reset
REQ-024 While clear=1 at a rising edge, the block SHALL set: row index 0 (row_n=4'b1110), dwell counter 0, synchronizer flops 3'b111, frame snapshot cleared, FSM=IDLE, cand=4'hF, cnt=0, keyboard=0, key_valid=0, key_code=4'hF.
REQ-025 clear asserted mid-frame or mid-press SHALL abort without emitting key_valid. Scanning SHALL restart at row 0 on the first clock after clear deasserts.

Configuration
REQ-026 With KEYPAD_STAR_HASH_EN defined, the block SHALL add outputs key_star and key_hash, each 1 bit. Each SHALL be high while star or hash respectively is HELD or in RELEASE, and each SHALL be 0 on reset.
REQ-027 Without KEYPAD_STAR_HASH_EN, those ports SHALL be absent. A star or hash press SHALL still run the FSM and key_code, and keyboard SHALL stay zero.

Structure
REQ-028 Package keypad_pkg SHALL hold: FSM state encoding, KEY_STAR=10, KEY_HASH=11, KEY_NONE=4'hF, the row/column-to-key-index map, and the frame classification codes.
REQ-029 The FSM with cand/cnt and the output registers SHALL be the sub-module keypad_debounce. It SHALL take a frame-done strobe plus the classification.
REQ-030 Row/column scanning and the synchronizer SHALL stay in the top level.

Verification (bench uses SCAN_DIV=4, DEBOUNCE_FRAMES=3; frame = 16 clocks)
REQ-031 Reset, no key: row_n cycles 1110,1101,1011,0111 every 4 clocks; keyboard=0 and key_code=F for 200 clocks.
REQ-032 Hold key 5 (row1, col1) for 10 frames: exactly one key_valid pulse, at the 3rd frame end plus 1 clock; keyboard=10'b0000100000 and key_code=5 until 3 NONE frames after release, then 0 and F.
REQ-033 Press 7 and bounce open for 1 frame inside CONFIRM: no key_valid; acceptance restarts and the pulse arrives 3 good frames later.
REQ-034 Hold 2, then press 2 and 8 together: MULTI drives RELEASE. Releasing 8 returns to HELD with no second pulse; keyboard stays 10'b0000000100.
REQ-035 Assert clear for 1 clock while 9 is HELD: keyboard=0 and key_code=F next clock, row_n=1110. With key 9 still down, a new key_valid follows 3 frames later.
REQ-036 With KEYPAD_STAR_HASH_EN, hold hash: key_valid pulses, key_code=11, key_hash=1, keyboard=0. Without the macro, the same stimulus gives key_code=11 and keyboard=0.
